// File: rtl/rhythm_game_pkg.sv
// Shared types and constants for the rhythm game engine.
// Holds FSM and judgement encodings plus scoring constants.
package rhythm_game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PLAYING  = 2'd1,
        ST_FINISHED = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        JG_NONE    = 2'd0,
        JG_PERFECT = 2'd1,
        JG_GOOD    = 2'd2,
        JG_MISS    = 2'd3
    } judge_e;

    localparam int PTS_PERFECT     = 3;
    localparam int PTS_GOOD        = 1;
    localparam int COMBO_BONUS_THR = 10;
    localparam int COMBO_W         = 8;

endpackage

// File: rtl/rhythm_note_fifo.sv
// Note FIFO: DEPTH entries of {mask,time}, head visible on dout.
// Pop frees a slot in the same cycle, so push on full+pop is accepted.
module rhythm_note_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 18,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Storage array; no reset needed, validity is tracked by count.
    always_ff @(posedge clk) begin
        if (do_push && !flush)
            mem[wr_ptr] <= din;
    end

    // Pointer and occupancy bookkeeping; flush empties the queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rhythm_game_core.sv
// Rhythm game engine: note FIFO, game timer, press judging, score/combo.
// Optional RHYTHM_COMBO_BONUS_EN adds +1 per hit while combo >= 10.
module rhythm_game_core #(
    parameter int LANES       = 8,
    parameter int TS_W        = 10,
    parameter int DEPTH       = 16,
    parameter int SCORE_W     = 11,
    parameter int TICK_DIV    = 500000,
    parameter int WIN_PERFECT = 2,
    parameter int WIN_GOOD    = 5
) (
    input  logic               CLOCK50M,
    input  logic               RESET_N,
    input  logic               start,
    input  logic               note_write,
    input  logic [LANES-1:0]   note_mask,
    input  logic [TS_W-1:0]    note_time,
    input  logic [LANES-1:0]   user_input,
    output logic               note_full,
    output logic               overflow,
    output logic [1:0]         game_state,
    output logic [TS_W-1:0]    game_timer,
    output logic               judge_valid,
    output logic [1:0]         judge_code,
    output logic [SCORE_W-1:0] score,
    output logic [7:0]         combo
);

    import rhythm_game_pkg::*;

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int FW = LANES + TS_W;
    localparam logic [TS_W:0] WP_V = (TS_W+1)'(WIN_PERFECT);
    localparam logic [TS_W:0] WG_V = (TS_W+1)'(WIN_GOOD);

    state_e               state_q, state_d;
    judge_e               jcode, judge_q;
    logic [LANES-1:0]     sync1, sync2, sync3;
    logic [LANES-1:0]     press;
    logic [PW-1:0]        pre_q;
    logic [TS_W-1:0]      timer_q;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [SCORE_W:0]     sum;
    logic [COMBO_W-1:0]   combo_q;
    logic [2:0]           pts;
    logic                 jv_q, ovf_q;
    logic                 flush, pop, fifo_empty, playing, start_go, hit;
    logic [FW-1:0]        head;
    logic [LANES-1:0]     head_mask;
    logic [TS_W-1:0]      head_time;
    logic [CW-1:0]        fifo_count;
    logic signed [TS_W:0] dt;
    logic [TS_W:0]        absdt;

    rhythm_note_fifo #(.DEPTH(DEPTH), .W(FW)) u_fifo (
        .clk   (CLOCK50M),
        .rst_n (RESET_N),
        .flush (flush),
        .push  (note_write),
        .pop   (pop),
        .din   ({note_mask, note_time}),
        .dout  (head),
        .full  (note_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign head_mask = head[FW-1:TS_W];
    assign head_time = head[TS_W-1:0];
    assign press     = sync2 & ~sync3;
    assign playing   = (state_q == ST_PLAYING);
    assign start_go  = start && !playing;
    assign hit       = |(press & head_mask);
    assign dt        = $signed({1'b0, timer_q}) - $signed({1'b0, head_time});
    assign absdt     = dt[TS_W] ? -dt : dt;
    assign pop       = (jcode != JG_NONE);
    assign sum       = {1'b0, score_q} + (SCORE_W+1)'(pts);
    assign score_d   = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];

    assign game_state  = state_q;
    assign game_timer  = timer_q;
    assign judge_valid = jv_q;
    assign judge_code  = judge_q;
    assign score       = score_q;
    assign combo       = combo_q;
    assign overflow    = ovf_q;

    // Judge the FIFO head against this cycle's presses and the timer.
    always_comb begin
        jcode = JG_NONE;
        if (playing && !fifo_empty) begin
            if (hit && absdt <= WP_V)
                jcode = JG_PERFECT;
            else if (hit && absdt <= WG_V)
                jcode = JG_GOOD;
            else if (!dt[TS_W] && absdt > WG_V)
                jcode = JG_MISS;
        end
    end

    // Points for the current judgement, with optional combo bonus.
    always_comb begin
        pts = 3'd0;
        unique case (1'b1)
            (jcode == JG_PERFECT): pts = 3'(PTS_PERFECT);
            (jcode == JG_GOOD):    pts = 3'(PTS_GOOD);
            default:               pts = 3'd0;
        endcase
`ifdef RHYTHM_COMBO_BONUS_EN
        if ((jcode == JG_PERFECT || jcode == JG_GOOD) &&
            combo_q >= COMBO_W'(COMBO_BONUS_THR))
            pts = pts + 3'd1;
`endif
    end

    // Game FSM; entering FINISHED flushes any leftover notes.
    always_comb begin
        state_d = state_q;
        flush   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_PLAYING;
            end
            ST_PLAYING: begin
                if (timer_q == '1 ||
                    (pop && fifo_count == CW'(1) && !note_write)) begin
                    state_d = ST_FINISHED;
                    flush   = 1'b1;
                end
            end
            ST_FINISHED: begin
                if (start) state_d = ST_PLAYING;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge CLOCK50M or negedge RESET_N) begin
        if (!RESET_N) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Two-flop synchroniser plus previous-value flop for edge detect.
    always_ff @(posedge CLOCK50M or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
        end else begin
            sync1 <= user_input;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    // Prescaler and saturating game timer, running only while playing.
    always_ff @(posedge CLOCK50M or negedge RESET_N) begin
        if (!RESET_N) begin
            pre_q   <= '0;
            timer_q <= '0;
        end else if (start_go) begin
            pre_q   <= '0;
            timer_q <= '0;
        end else if (playing) begin
            if (pre_q == PW'(TICK_DIV - 1)) begin
                pre_q <= '0;
                if (timer_q != '1) timer_q <= timer_q + TS_W'(1);
            end else begin
                pre_q <= pre_q + PW'(1);
            end
        end
    end

    // Register judgement pulse, score and combo.
    always_ff @(posedge CLOCK50M or negedge RESET_N) begin
        if (!RESET_N) begin
            jv_q    <= 1'b0;
            judge_q <= JG_NONE;
            score_q <= '0;
            combo_q <= '0;
        end else begin
            jv_q    <= pop;
            judge_q <= jcode;
            if (start_go) begin
                score_q <= '0;
                combo_q <= '0;
            end else if (pop) begin
                score_q <= score_d;
                if (jcode == JG_MISS)
                    combo_q <= '0;
                else if (combo_q != '1)
                    combo_q <= combo_q + COMBO_W'(1);
            end
        end
    end

    // Sticky flag for a note write dropped on a full FIFO.
    always_ff @(posedge CLOCK50M or negedge RESET_N) begin
        if (!RESET_N)
            ovf_q <= 1'b0;
        else if (note_write && note_full && !pop)
            ovf_q <= 1'b1;
    end

endmodule

// File: tb/tb_rhythm_game_core.sv
// Directed bench for rhythm_game_core with TICK_DIV=4.
// Expected values are hand-derived from the judging windows and scoring.
module tb_rhythm_game_core;

    logic        CLOCK50M = 1'b0;
    logic        RESET_N = 1'b0;
    logic        start = 1'b0;
    logic        note_write = 1'b0;
    logic [7:0]  note_mask = '0;
    logic [9:0]  note_time = '0;
    logic [7:0]  user_input = '0;
    logic        note_full;
    logic        overflow;
    logic [1:0]  game_state;
    logic [9:0]  game_timer;
    logic        judge_valid;
    logic [1:0]  judge_code;
    logic [10:0] score;
    logic [7:0]  combo;

    int n_run = 0;
    int n_fail = 0;

`ifdef RHYTHM_COMBO_BONUS_EN
    localparam int EXP12 = 38;
`else
    localparam int EXP12 = 36;
`endif

    rhythm_game_core #(.TICK_DIV(4)) dut (
        .CLOCK50M    (CLOCK50M),
        .RESET_N     (RESET_N),
        .start       (start),
        .note_write  (note_write),
        .note_mask   (note_mask),
        .note_time   (note_time),
        .user_input  (user_input),
        .note_full   (note_full),
        .overflow    (overflow),
        .game_state  (game_state),
        .game_timer  (game_timer),
        .judge_valid (judge_valid),
        .judge_code  (judge_code),
        .score       (score),
        .combo       (combo)
    );

    always #5 CLOCK50M = ~CLOCK50M;

    task automatic step();
        @(posedge CLOCK50M);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push_note(input logic [7:0] m, input logic [9:0] t);
        note_mask  = m;
        note_time  = t;
        note_write = 1'b1;
        step();
        note_write = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_timer(input logic [9:0] v);
        int n = 0;
        while (game_timer != v && n < 3000) begin
            step();
            n++;
        end
        chk("wait_timer", game_timer, v);
    endtask

    task automatic wait_judge();
        int n = 0;
        while (!judge_valid && n < 400) begin
            step();
            n++;
        end
        chk("wait_judge", judge_valid, 1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, game_state, 0);
        chk({tag, "_timer"}, game_timer, 0);
        chk({tag, "_score"}, score, 0);
        chk({tag, "_combo"}, combo, 0);
        chk({tag, "_full"}, note_full, 0);
        chk({tag, "_ovf"}, overflow, 0);
        chk({tag, "_jv"}, judge_valid, 0);
        chk({tag, "_jc"}, judge_code, 0);
    endtask

    initial begin
        repeat (3) step();
        chk_reset_vals("rst");
        RESET_N = 1'b1;
        step();

        // PERFECT on time
        push_note(8'h01, 10'd10);
        pulse_start();
        chk("t1_state", game_state, 1);
        wait_timer(10'd10);
        user_input = 8'h01;
        wait_judge();
        chk("t1_code", judge_code, 1);
        chk("t1_score", score, 3);
        chk("t1_combo", combo, 1);
        chk("t1_fin", game_state, 2);
        user_input = 8'h00;
        step();

        // GOOD then MISS by timeout
        push_note(8'h01, 10'd10);
        push_note(8'h01, 10'd30);
        pulse_start();
        chk("t2_score0", score, 0);
        chk("t2_combo0", combo, 0);
        wait_timer(10'd14);
        user_input = 8'h01;
        wait_judge();
        chk("t2_good", judge_code, 2);
        chk("t2_score", score, 1);
        chk("t2_combo", combo, 1);
        chk("t2_play", game_state, 1);
        user_input = 8'h00;
        step();
        wait_judge();
        chk("t2_miss", judge_code, 3);
        chk("t2_mtime", game_timer, 36);
        chk("t2_mcombo", combo, 0);
        chk("t2_mscore", score, 1);
        chk("t2_fin", game_state, 2);

        // press outside mask is ignored, then MISS
        push_note(8'h01, 10'd10);
        pulse_start();
        wait_timer(10'd10);
        user_input = 8'h08;
        wait_judge();
        chk("t3_code", judge_code, 3);
        chk("t3_time", game_timer, 16);
        chk("t3_score", score, 0);
        user_input = 8'h00;
        step();

        // FIFO full, push+pop on full, overflow
        for (int i = 0; i < 16; i++)
            push_note(8'h01, 10'(10 * (i + 1)));
        chk("t4_full", note_full, 1);
        chk("t4_ovf0", overflow, 0);
        pulse_start();
        wait_timer(10'd10);
        user_input = 8'h01;
        step();
        step();
        note_mask  = 8'h01;
        note_time  = 10'd200;
        note_write = 1'b1;
        step();
        note_write = 1'b0;
        chk("t4_pp_jv", judge_valid, 1);
        chk("t4_pp_code", judge_code, 1);
        chk("t4_pp_full", note_full, 1);
        chk("t4_pp_ovf", overflow, 0);
        user_input = 8'h00;
        push_note(8'h01, 10'd210);
        chk("t4_ovf", overflow, 1);
        chk("t4_full2", note_full, 1);
        chk("t4_mid_st", game_state, 1);

        // asynchronous reset mid-game
        RESET_N = 1'b0;
        #2;
        chk_reset_vals("mid");
        step();
        RESET_N = 1'b1;
        step();

        // 12 consecutive PERFECT
        for (int k = 1; k <= 12; k++)
            push_note(8'h01, 10'(10 * k));
        pulse_start();
        for (int k = 1; k <= 12; k++) begin
            wait_timer(10'(10 * k));
            user_input = 8'h01;
            wait_judge();
            chk($sformatf("t5_p%0d", k), judge_code, 1);
            user_input = 8'h00;
            step();
        end
        chk("t5_score", score, EXP12);
        chk("t5_combo", combo, 12);
        chk("t5_fin", game_state, 2);

        // timer saturates at all-ones and ends the game
        pulse_start();
        chk("t6_play", game_state, 1);
        begin
            int n = 0;
            while (game_state != 2'd2 && n < 5000) begin
                step();
                n++;
            end
        end
        chk("t6_fin", game_state, 2);
        chk("t6_timer", game_timer, 1023);
        repeat (8) step();
        chk("t6_sat", game_timer, 1023);
        chk("t6_jv", judge_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
